// File: rtl/keccak_lane_mem.sv
// keccak_lane_mem: 25-lane Keccak state store (lane index = 5*y + x) with two
// registered read ports, one overwrite/XOR-absorb write port, a self-running
// init sweep after reset or clr, and a sticky out-of-range coordinate flag.
// Optional feature: define KLM_FWD_EN so that a read of the lane being written
// in the same cycle returns the post-write value instead of the old one.
module keccak_lane_mem #(
    parameter int unsigned   LW       = 64,
    parameter logic [LW-1:0] INIT_VAL = LW'(64'hdeaddeaddeaddead)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    input  logic [2:0]    rx0,
    input  logic [2:0]    ry0,
    output logic [LW-1:0] rd0,
    input  logic [2:0]    rx1,
    input  logic [2:0]    ry1,
    output logic [LW-1:0] rd1,
    input  logic [2:0]    wx,
    input  logic [2:0]    wy,
    input  logic          wr,
    input  logic          wmode,
    input  logic [LW-1:0] wd,
    output logic          err
);
    localparam int unsigned NLANES = 25;
    localparam logic [4:0]  LAST   = 5'd24;

    typedef enum logic {SWEEP = 1'b0, READY = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [4:0]    ptr_q, ptr_d;
    logic          err_q, err_d;
    logic [LW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [LW-1:0] mem_q [NLANES];
    logic [LW-1:0] mem_d [NLANES];

    logic          ready, w_ok, r0_ok, r1_ok, wr_en, bad_access;
    logic [4:0]    widx, r0idx, r1idx;
    logic [LW-1:0] wnew, r0_val, r1_val;

    function automatic logic coord_ok(input logic [2:0] x, input logic [2:0] y);
        return (x <= 3'd4) && (y <= 3'd4);
    endfunction

    // Out-of-range coordinates map to lane 0; callers never use that value.
    function automatic logic [4:0] lane_idx(input logic [2:0] x, input logic [2:0] y);
        return coord_ok(x, y) ? (5'(y) * 5'd5 + 5'(x)) : 5'd0;
    endfunction

    // State register: reset always restarts the sweep from lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: walk lanes 0..24 once, clr restarts the walk from anywhere.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            SWEEP: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 5'd1;
                end
            end
            READY: begin
                if (clr) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    // Outputs: rst forces the idle/busy view immediately, even before the edge.
    always_comb begin
        busy = rst || (state_q == SWEEP);
        rd0  = rst ? '0 : rd0_q;
        rd1  = rst ? '0 : rd1_q;
        err  = err_q && !rst;
    end

    // Access decode: range checks, lane indices and the value a write produces.
    always_comb begin
        ready      = (state_q == READY);
        w_ok       = coord_ok(wx, wy);
        r0_ok      = coord_ok(rx0, ry0);
        r1_ok      = coord_ok(rx1, ry1);
        widx       = lane_idx(wx, wy);
        r0idx      = lane_idx(rx0, ry0);
        r1idx      = lane_idx(rx1, ry1);
        wr_en      = ready && !clr && wr && w_ok;
        wnew       = wmode ? (mem_q[widx] ^ wd) : wd;
        bad_access = (wr && !w_ok) || !r0_ok || !r1_ok;
    end

    // Read data: zero while sweeping, on clr, or for an out-of-range port.
    always_comb begin
        r0_val = mem_q[r0idx];
        r1_val = mem_q[r1idx];
`ifdef KLM_FWD_EN
        if (wr_en && (widx == r0idx)) r0_val = wnew;
        if (wr_en && (widx == r1idx)) r1_val = wnew;
`endif
        rd0_d = (ready && !clr && r0_ok) ? r0_val : '0;
        rd1_d = (ready && !clr && r1_ok) ? r1_val : '0;
    end

    // Sticky error: only READY accesses can raise it, clr always clears it.
    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = 1'b0;
        end else if (ready && bad_access) begin
            err_d = 1'b1;
        end
    end

    // Lane updates: sweep writes INIT_VAL, READY writes overwrite or absorb.
    always_comb begin
        mem_d = mem_q;
        if (!rst) begin
            if (!ready && !clr) mem_d[ptr_q] = INIT_VAL;
            if (wr_en)          mem_d[widx]  = wnew;
        end
    end

    // Datapath registers: read data and error flag reset, lanes do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            err_q <= err_d;
            rd0_q <= rd0_d;
            rd1_q <= rd1_d;
        end
    end

    // Lane storage, initialised by the sweep rather than by rst.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_keccak_lane_mem.sv
// tb_keccak_lane_mem: directed literal checks plus randomized traffic compared
// every cycle against a lane-array model; a second LW=8 instance covers the
// narrow build.
module tb_keccak_lane_mem;
    localparam logic [63:0] INIT = 64'hdeaddeaddeaddead;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic        rst = 1'b1, clr = 1'b0, busy, err;
    logic [2:0]  rx0 = '0, ry0 = '0, rx1 = '0, ry1 = '0, wx = '0, wy = '0;
    logic        wr = 1'b0, wmode = 1'b0;
    logic [63:0] wd = '0, rd0, rd1;

    logic        r8 = 1'b1, clr8 = 1'b0, busy8, err8, wr8 = 1'b0, wm8 = 1'b0;
    logic [2:0]  rx08 = '0, ry08 = '0, rx18 = '0, ry18 = '0, wx8 = '0, wy8 = '0;
    logic [7:0]  wd8 = '0, rd08, rd18;

    keccak_lane_mem dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .rx0(rx0), .ry0(ry0), .rd0(rd0), .rx1(rx1), .ry1(ry1), .rd1(rd1),
        .wx(wx), .wy(wy), .wr(wr), .wmode(wmode), .wd(wd), .err(err)
    );

    keccak_lane_mem #(.LW(8)) dut8 (
        .clk(clk), .rst(r8), .clr(clr8), .busy(busy8),
        .rx0(rx08), .ry0(ry08), .rd0(rd08), .rx1(rx18), .ry1(ry18), .rd1(rd18),
        .wx(wx8), .wy(wy8), .wr(wr8), .wmode(wm8), .wd(wd8), .err(err8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a busy countdown plus a plain array of 25 lanes. Any sweep is
    // unobservable from outside, so lanes snap to INIT as soon as one starts.
    int          m_cnt = 0;
    logic [63:0] m_lane [25];
    logic [63:0] m_rd0 = '0, m_rd1 = '0;
    logic        m_err = 1'b0;

    task automatic model_step();
        logic        ok0, ok1, okw;
        int          i0, i1, iw;
        logic [63:0] v0, v1, nv;
        if (rst) begin
            m_cnt = 25; m_err = 1'b0; m_rd0 = '0; m_rd1 = '0;
            for (int i = 0; i < 25; i++) m_lane[i] = INIT;
        end else if (m_cnt > 0) begin
            m_rd0 = '0; m_rd1 = '0;
            m_cnt = clr ? 25 : m_cnt - 1;
        end else if (clr) begin
            m_cnt = 25; m_err = 1'b0; m_rd0 = '0; m_rd1 = '0;
            for (int i = 0; i < 25; i++) m_lane[i] = INIT;
        end else begin
            ok0 = (rx0 < 3'd5) && (ry0 < 3'd5);
            ok1 = (rx1 < 3'd5) && (ry1 < 3'd5);
            okw = (wx < 3'd5) && (wy < 3'd5);
            i0 = ok0 ? 5 * int'(ry0) + int'(rx0) : 0;
            i1 = ok1 ? 5 * int'(ry1) + int'(rx1) : 0;
            iw = okw ? 5 * int'(wy) + int'(wx) : 0;
            v0 = m_lane[i0];
            v1 = m_lane[i1];
            if (wr && okw) begin
                nv = wmode ? (m_lane[iw] ^ wd) : wd;
`ifdef KLM_FWD_EN
                if (iw == i0) v0 = nv;
                if (iw == i1) v1 = nv;
`endif
                m_lane[iw] = nv;
            end
            m_rd0 = ok0 ? v0 : 64'd0;
            m_rd1 = ok1 ? v1 : 64'd0;
            if ((wr && !okw) || !ok0 || !ok1) m_err = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle compare of all outputs against the model.
    initial forever begin
        @(negedge clk);
        chk("busy", 64'(busy), 64'(rst || (m_cnt > 0)));
        chk("rd0", rd0, rst ? 64'd0 : m_rd0);
        chk("rd1", rd1, rst ? 64'd0 : m_rd1);
        chk("err", 64'(err), 64'(m_err && !rst));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; wr = 1'b0; wmode = 1'b0; wd = '0;
        wx = '0; wy = '0; rx0 = '0; ry0 = '0; rx1 = '0; ry1 = '0;
    endtask

    function automatic logic [2:0] rc();
        return ($urandom_range(0, 63) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    endfunction

    initial begin
        int n;
        logic [63:0] exp35;

        // Reset state.
        idle();
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rd0", rd0, 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // Release: busy for exactly 25 cycles, then INIT everywhere.
        rst = 1'b0;
        r8 = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("busy_cycles_after_rst", 64'(n), 64'd25);
        rx0 = 3'd0; ry0 = 3'd0; rx1 = 3'd4; ry1 = 3'd4;
        tick();
        chk("rd_00_init", rd0, INIT);
        chk("rd_44_init", rd1, INIT);

        // Overwrite then XOR-absorb lane (2,3).
        idle();
        wx = 3'd2; wy = 3'd3; wd = 64'h0123456789abcdef; wr = 1'b1;
        tick();
        wmode = 1'b1; wd = 64'hffffffff00000000;
        tick();
        idle();
        rx1 = 3'd2; ry1 = 3'd3;
        tick();
        chk("absorb_23", rd1, 64'hfedcba9889abcdef);

        // Same-cycle write and read of lane (1,1).
`ifdef KLM_FWD_EN
        exp35 = 64'h5;
`else
        exp35 = INIT;
`endif
        idle();
        wx = 3'd1; wy = 3'd1; wd = 64'h5; wr = 1'b1;
        rx0 = 3'd1; ry0 = 3'd1;
        tick();
        wr = 1'b0;
        chk("same_cycle_rd", rd0, exp35);
        tick();
        chk("after_write_rd", rd0, 64'h5);

        // Out-of-range write and read.
        idle();
        chk("err_clean", 64'(err), 64'd0);
        wx = 3'd5; wy = 3'd0; wd = 64'h1234; wr = 1'b1;
        tick();
        idle();
        chk("err_on_bad_write", 64'(err), 64'd1);
        rx0 = 3'd0; ry0 = 3'd7; rx1 = 3'd0; ry1 = 3'd1;
        tick();
        chk("bad_read_zero", rd0, 64'd0);
        chk("no_alias_write", rd1, INIT);
        idle();
        repeat (3) tick();
        chk("err_sticky", 64'(err), 64'd1);

        // clr clears err; a second clr mid-sweep restarts it; busy writes drop.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("err_cleared_by_clr", 64'(err), 64'd0);
        chk("busy_after_clr", 64'(busy), 64'd1);
        repeat (10) tick();
        clr = 1'b1; wr = 1'b1; wx = 3'd0; wy = 3'd0; wd = '0;
        tick();
        clr = 1'b0; wx = 3'd1; wy = 3'd1;
        n = 0;
        while (busy && n < 100) begin tick(); n++; wr = 1'b0; end
        chk("busy_cycles_after_clr", 64'(n), 64'd25);
        idle();
        for (int i = 0; i < 25; i++) begin
            rx0 = 3'(i % 5); ry0 = 3'(i / 5);
            tick();
            chk($sformatf("lane%0d_init", i), rd0, INIT);
        end

        // Randomized traffic, checked by the every-cycle compare.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 499) == 0);
            clr   = ($urandom_range(0, 59) == 0);
            wr    = 1'($urandom_range(0, 1));
            wmode = 1'($urandom_range(0, 1));
            wx = rc(); wy = rc();
            wd = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) begin rx0 = wx; ry0 = wy; end
            else begin rx0 = rc(); ry0 = rc(); end
            if ($urandom_range(0, 3) == 0) begin rx1 = wx; ry1 = wy; end
            else begin rx1 = rc(); ry1 = rc(); end
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (30) tick();

        // Narrow build: INIT truncates to 8'had, absorbing 8'hff gives 8'h52.
        chk("w8_busy", 64'(busy8), 64'd0);
        rx08 = 3'd4; ry08 = 3'd0;
        tick();
        chk("w8_init", 64'(rd08), 64'h00000000000000ad);
        wx8 = 3'd4; wy8 = 3'd0; wr8 = 1'b1; wm8 = 1'b1; wd8 = 8'hff;
        tick();
        wr8 = 1'b0; wm8 = 1'b0;
        tick();
        chk("w8_absorb", 64'(rd08), 64'h0000000000000052);
        chk("w8_err", 64'(err8), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
